irq_controller: RTL

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_ctrl_pkg.sv | 15 +
 rtl/irq_controller_if.sv | 34 +++
 rtl/priority_encoder.sv | 24 ++
 rtl/irq_controller.sv | 106 ++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg
// Shared widths and FSM state encoding for the interrupt controller.
//   IRQ_W      number of interrupt request lines
//   VEC_W      width of the vector index (log2 of IRQ_W)
//   ST_*       controller FSM state encoding
package irq_ctrl_pkg;

  localparam int IRQ_W = 8;
  localparam int VEC_W = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if
// Vector handshake between the interrupt controller and its consumer.
//   vec_out    selected request index, held while offered
//   vec_valid  vec_out holds an offered vector
//   vec_ready  consumer accepts the vector when high with vec_valid
//   eoi        end-of-interrupt pulse from the consumer
//   busy       a vector is in service (accepted, eoi not yet seen)
// Modports: master = controller side, slave = consumer side.
interface irq_controller_if;
  import irq_ctrl_pkg::*;

  logic [VEC_W-1:0] vec_out;
  logic             vec_valid;
  logic             vec_ready;
  logic             eoi;
  logic             busy;

  modport master (
    output vec_out,
    output vec_valid,
    output busy,
    input  vec_ready,
    input  eoi
  );

  modport slave (
    input  vec_out,
    input  vec_valid,
    input  busy,
    output vec_ready,
    output eoi
  );

endinterface

// File: rtl/priority_encoder.sv
// priority_encoder
// 8-to-3 priority encoder; the highest set input bit wins.
//   in     request vector
//   out    index of the highest set bit (0 when nothing is set)
//   valid  any bit of in is set
module priority_encoder
  import irq_ctrl_pkg::*;
(
  input  logic [IRQ_W-1:0] in,
  output logic [VEC_W-1:0] out,
  output logic             valid
);

  // Ascending scan: later (higher) indices overwrite lower ones.
  always_comb begin
    out = '0;
    for (int i = 0; i < IRQ_W; i++) begin
      if (in[i]) out = VEC_W'(i);
    end
  end

  assign valid = |in;

endmodule

// File: rtl/irq_controller.sv
// irq_controller
// Captures interrupt requests into a pending register, offers the highest
// priority unmasked request as a vector over a valid/ready handshake and
// holds it in service until the consumer signals end-of-interrupt.
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   irq_in     raw request lines, bit 7 highest priority
//   mask       1 = line blocked from selection (still captured)
//   pending    registered pending requests
//   vec_bus    vector handshake (master side)
// LEVEL_MODE: 0 = capture rising edges of irq_in, 1 = capture while high.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no vector offered; picks the best candidate when one exists
// ST_PRESENT | vec_out offered with vec_valid, frozen until accepted
// ST_SERVICE | vector accepted, busy until eoi
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IRQ_W-1:0]  irq_in,
  input  logic [IRQ_W-1:0]  mask,
  output logic [IRQ_W-1:0]  pending,
  irq_controller_if.master  vec_bus
);

  logic [1:0]       state;
  logic [IRQ_W-1:0] irq_prev;
  logic [IRQ_W-1:0] set_vec;
  logic [IRQ_W-1:0] clr_vec;
  logic [IRQ_W-1:0] cand;
  logic [VEC_W-1:0] sel_idx;
  logic             sel_valid;
  logic [VEC_W-1:0] vec_q;
  logic             valid_q;
  logic             busy_q;

  assign cand = pending & ~mask;

  priority_encoder u_penc (
    .in    (cand),
    .out   (sel_idx),
    .valid (sel_valid)
  );

  // irq_prev resets to 0, so a line held high across reset release is seen
  // as a fresh edge in the first cycle after reset.
  assign set_vec = LEVEL_MODE ? irq_in : (irq_in & ~irq_prev);

  always_comb begin
    clr_vec = '0;
    if (state == ST_PRESENT && vec_bus.vec_ready) clr_vec[vec_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pending  <= '0;
      irq_prev <= '0;
      vec_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // A request arriving on the same edge as the clear is kept.
      pending  <= (pending & ~clr_vec) | set_vec;
      irq_prev <= irq_in;

      unique case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            vec_q   <= sel_idx;
            valid_q <= 1'b1;
            state   <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (vec_bus.vec_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (vec_bus.eoi) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign vec_bus.vec_out   = vec_q;
  assign vec_bus.vec_valid = valid_q;
  assign vec_bus.busy      = busy_q;

endmodule
